// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and RGB332 field widths
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;
endpackage

// File: rtl/vga_scan_out_scan_counter.sv
// scan_counter: pixel divider plus free-running h/v raster counters
module scan_counter #(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL,
  parameter int PIX_DIV = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en,
  output logic       frame_start
);
  logic div;
  logic h_wrap;
  logic v_wrap;
  assign pix_en = (PIX_DIV == 1) || div;
  assign h_wrap = hcount == 10'(H_TOTAL - 1);
  assign v_wrap = vcount == 10'(V_TOTAL - 1);
  // gated by reset_n so no pulse escapes while the counters are held at (0,0)
  assign frame_start = reset_n && pix_en && hcount == '0 && vcount == '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      div <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= (PIX_DIV == 2) && !div;
      if (pix_en) begin
        hcount <= h_wrap ? '0 : hcount + 10'd1;
        if (h_wrap) vcount <= v_wrap ? '0 : vcount + 10'd1;
      end
    end
endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: raster timing, two-layer RGB332 compositing and sync/de alignment
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int SYNC_POL = 0,
  parameter int PIX_DIV = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  output logic [9:0]     hcount,
  output logic [9:0]     vcount,
  output logic           pix_en,
  output logic           frame_start,
  input  logic [R_W-1:0] menu_red,
  input  logic [G_W-1:0] menu_green,
  input  logic [B_W-1:0] menu_blue,
  input  logic           menu_layer,
  input  logic [R_W-1:0] game_red,
  input  logic [G_W-1:0] game_green,
  input  logic [B_W-1:0] game_blue,
  output logic [R_W-1:0] vga_r,
  output logic [G_W-1:0] vga_g,
  output logic [B_W-1:0] vga_b,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           vga_de
);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam logic ACT = 1'(SYNC_POL);
  logic de_raw, hs_raw, vs_raw;
  logic de_d, hs_d, vs_d;
  scan_counter #(
    .H_TOTAL(H_ACTIVE + H_FP + H_SYNC + H_BP),
    .V_TOTAL(V_ACTIVE + V_FP + V_SYNC + V_BP),
    .PIX_DIV(PIX_DIV)
  ) u_cnt (
    .clock(clock),
    .reset_n(reset_n),
    .hcount(hcount),
    .vcount(vcount),
    .pix_en(pix_en),
    .frame_start(frame_start)
  );
  assign de_raw = hcount < 10'(H_ACTIVE) && vcount < 10'(V_ACTIVE);
  assign hs_raw = hcount >= 10'(HS_BEG) && hcount < 10'(HS_BEG + H_SYNC);
  assign vs_raw = vcount >= 10'(VS_BEG) && vcount < 10'(VS_BEG + V_SYNC);
  // first stage matches the layer generators' RGB register, second stage meets the colour mux
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      de_d <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      vga_de <= 1'b0;
      vga_hs <= ~ACT;
      vga_vs <= ~ACT;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      de_d <= de_raw;
      hs_d <= hs_raw;
      vs_d <= vs_raw;
      vga_de <= de_d;
      vga_hs <= hs_d ? ACT : ~ACT;
      vga_vs <= vs_d ? ACT : ~ACT;
      vga_r <= !de_d ? '0 : menu_layer ? menu_red : game_red;
      vga_g <= !de_d ? '0 : menu_layer ? menu_green : game_green;
      vga_b <= !de_d ? '0 : menu_layer ? menu_blue : game_blue;
    end
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: scoreboard bench over default, PIX_DIV=2 and a shrunken raster
module tb_vga_scan_out;
  typedef enum int {F_H, F_V, F_PE, F_FS, F_HS, F_VS, F_DE, F_RGB} fld_e;
  typedef struct {
    int i;
    fld_e f;
    int at;
    logic [31:0] v;
  } chk_t;
  chk_t q[$];
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic menu_layer = 1'b1;
  logic [2:0] menu_red = 3'b111, menu_green = 3'b111, game_red = 3'b001, game_green = 3'b010;
  logic [1:0] menu_blue = 2'b11, game_blue = 2'b01;
  logic [9:0] hc[3], vc[3];
  logic pe[3], fs[3], hs[3], vs[3], de[3];
  logic [2:0] r[3], g[3];
  logic [1:0] b[3];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] got;

  always #5 clock = ~clock;
  always @(posedge clock or negedge reset_n) cyc <= reset_n ? cyc + 1 : 0;

  vga_scan_out u_a (
    .clock(clock), .reset_n(reset_n), .hcount(hc[0]), .vcount(vc[0]), .pix_en(pe[0]),
    .frame_start(fs[0]), .menu_red(menu_red), .menu_green(menu_green), .menu_blue(menu_blue),
    .menu_layer(menu_layer), .game_red(game_red), .game_green(game_green), .game_blue(game_blue),
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0])
  );
  vga_scan_out #(.PIX_DIV(2)) u_b (
    .clock(clock), .reset_n(reset_n), .hcount(hc[1]), .vcount(vc[1]), .pix_en(pe[1]),
    .frame_start(fs[1]), .menu_red(menu_red), .menu_green(menu_green), .menu_blue(menu_blue),
    .menu_layer(menu_layer), .game_red(game_red), .game_green(game_green), .game_blue(game_blue),
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1])
  );
  vga_scan_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) u_c (
    .clock(clock), .reset_n(reset_n), .hcount(hc[2]), .vcount(vc[2]), .pix_en(pe[2]),
    .frame_start(fs[2]), .menu_red(menu_red), .menu_green(menu_green), .menu_blue(menu_blue),
    .menu_layer(menu_layer), .game_red(game_red), .game_green(game_green), .game_blue(game_blue),
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_de(de[2])
  );

  function automatic logic [31:0] val(int i, fld_e f);
    case (f)
      F_H: return 32'(hc[i]);
      F_V: return 32'(vc[i]);
      F_PE: return 32'(pe[i]);
      F_FS: return 32'(fs[i]);
      F_HS: return 32'(hs[i]);
      F_VS: return 32'(vs[i]);
      F_DE: return 32'(de[i]);
      default: return 32'({r[i], g[i], b[i]});
    endcase
  endfunction

  task automatic expect_at(int i, fld_e f, int at, logic [31:0] v);
    q.push_back('{i, f, at, v});
  endtask

  task automatic rst_chk(int i, logic pe_v);
    expect_at(i, F_H, -1, 0);
    expect_at(i, F_V, -1, 0);
    expect_at(i, F_PE, -1, 32'(pe_v));
    expect_at(i, F_FS, -1, 0);
    expect_at(i, F_HS, -1, 1);
    expect_at(i, F_VS, -1, 1);
    expect_at(i, F_DE, -1, 0);
    expect_at(i, F_RGB, -1, 0);
  endtask

  task automatic wait_cyc(int n);
    for (int j = 0; j < 5000 && cyc < n; j++) @(negedge clock);
  endtask

  always @(negedge clock)
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].at < 0 ? !reset_n : (reset_n && q[k].at == cyc)) begin
        got = val(q[k].i, q[k].f);
        checks++;
        if (got !== q[k].v) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d got %0h want %0h", q[k].f.name(), q[k].i, q[k].at, got, q[k].v);
        end
        q.delete(k);
      end

  initial begin
    for (int i = 0; i < 3; i++) rst_chk(i, i != 1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    expect_at(0, F_FS, 0, 1); expect_at(0, F_H, 0, 0); expect_at(0, F_V, 0, 0);
    expect_at(0, F_DE, 0, 0); expect_at(0, F_FS, 1, 0); expect_at(0, F_H, 1, 1);
    expect_at(0, F_DE, 1, 0); expect_at(0, F_DE, 2, 1); expect_at(0, F_RGB, 100, 32'hFF);
    expect_at(0, F_DE, 641, 1); expect_at(0, F_DE, 642, 0);
    expect_at(0, F_HS, 657, 1); expect_at(0, F_HS, 658, 0);
    expect_at(0, F_HS, 753, 0); expect_at(0, F_HS, 754, 1);
    expect_at(0, F_RGB, 702, 0); expect_at(0, F_H, 799, 799);
    expect_at(0, F_H, 800, 0); expect_at(0, F_V, 800, 1); expect_at(0, F_PE, 800, 1);
    expect_at(0, F_RGB, 999, 32'hFF); expect_at(0, F_RGB, 1003, 32'h29);
    expect_at(0, F_RGB, 1500, 0); expect_at(0, F_H, 1599, 799); expect_at(0, F_V, 1600, 2);
    expect_at(1, F_PE, 0, 0); expect_at(1, F_PE, 1, 1); expect_at(1, F_PE, 2, 0);
    expect_at(1, F_FS, 0, 0); expect_at(1, F_FS, 1, 1); expect_at(1, F_FS, 3, 0);
    expect_at(1, F_H, 3, 1); expect_at(1, F_DE, 1, 0); expect_at(1, F_DE, 2, 1);
    expect_at(1, F_RGB, 1003, 32'h29); expect_at(1, F_DE, 1281, 1); expect_at(1, F_DE, 1282, 0);
    expect_at(1, F_RGB, 1282, 0); expect_at(1, F_HS, 1313, 1); expect_at(1, F_HS, 1314, 0);
    expect_at(1, F_HS, 1505, 0); expect_at(1, F_HS, 1506, 1);
    expect_at(1, F_H, 1599, 799); expect_at(1, F_H, 1600, 0); expect_at(1, F_V, 1600, 1);
    expect_at(2, F_FS, 0, 1); expect_at(2, F_FS, 1, 0); expect_at(2, F_HS, 11, 1);
    expect_at(2, F_HS, 12, 0); expect_at(2, F_HS, 14, 0); expect_at(2, F_HS, 15, 1);
    expect_at(2, F_VS, 81, 1); expect_at(2, F_VS, 82, 0); expect_at(2, F_VS, 97, 0);
    expect_at(2, F_VS, 98, 1); expect_at(2, F_FS, 127, 0); expect_at(2, F_H, 127, 15);
    expect_at(2, F_V, 127, 7); expect_at(2, F_FS, 128, 1); expect_at(2, F_H, 128, 0);
    expect_at(2, F_V, 128, 0); expect_at(2, F_DE, 129, 0); expect_at(2, F_DE, 130, 1);
    expect_at(2, F_FS, 256, 1);
    wait_cyc(1000);
    #1 menu_layer = 1'b0;
    wait_cyc(1900);
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) rst_chk(i, i != 1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    expect_at(0, F_FS, 0, 1); expect_at(0, F_H, 0, 0); expect_at(0, F_V, 0, 0);
    expect_at(0, F_FS, 1, 0); expect_at(0, F_DE, 1, 0); expect_at(0, F_RGB, 1, 0);
    expect_at(0, F_DE, 2, 1); expect_at(0, F_RGB, 3, 32'h29); expect_at(0, F_H, 5, 5);
    expect_at(0, F_V, 5, 0);
    @(negedge clock);
    checks += 3;
    if (fs[0] !== 1'b1) begin
      errors++;
      $display("FAIL direct frame_start after restart got %0b", fs[0]);
    end
    if (hc[0] !== 10'd0) begin
      errors++;
      $display("FAIL direct hcount after restart got %0d", hc[0]);
    end
    if (vc[0] !== 10'd0) begin
      errors++;
      $display("FAIL direct vcount after restart got %0d", vc[0]);
    end
    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clock);
    foreach (q[k]) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d cyc %0d never observed want %0h", q[k].f.name(), q[k].i, q[k].at, q[k].v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, SYNC_POL 0 (0 = active-low sync), PIX_DIV 1 (legal values 1 or 2; clocks per pixel).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  system/pixel clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 hcount  out  10  current pixel column, broadcast to all layer generators.
REQ-006 vcount  out  10  current pixel row, broadcast to all layer generators.
REQ-007 pix_en  out  1  one-clock strobe marking each pixel advance; tied high when PIX_DIV=1.
REQ-008 frame_start  out  1  one-clock pulse at the start of each frame.
REQ-009 menu_red/menu_green  in  3 each  registered menu layer colour.
REQ-010 menu_blue  in  2  registered menu layer colour.
REQ-011 menu_layer  in  1  high = menu layer owns the pixel.
REQ-012 game_red/game_green  in  3 each  registered game layer colour.
REQ-013 game_blue  in  2  registered game layer colour.
REQ-014 vga_r/vga_g  out  3 each  final RGB332 colour.
REQ-015 vga_b  out  2  final RGB332 colour.
REQ-016 vga_hs  out  1  horizontal sync, polarity per SYNC_POL.
REQ-017 vga_vs  out  1  vertical sync, polarity per SYNC_POL.
REQ-018 vga_de  out  1  active-video flag.

Function
REQ-019 SHALL compute H_TOTAL = sum of the four H parameters (800) and V_TOTAL = sum of the four V parameters (525).
REQ-020 SHALL free-run a divider that asserts pix_en every PIX_DIV-th clock.
REQ-021 SHALL increment hcount on pix_en and wrap H_TOTAL-1 -> 0.
REQ-022 SHALL increment vcount on the same pix_en in which hcount wraps, and wrap V_TOTAL-1 -> 0 there (799,524 -> 0,0).
REQ-023 SHALL hold hcount and vcount while pix_en is low.
REQ-024 SHALL derive raw signals from the counter stage: de_raw = hcount < H_ACTIVE and vcount < V_ACTIVE; hs_raw active for hcount 656..751; vs_raw active for vcount 490..491.
REQ-025 SHALL drive frame_start for exactly one clock: the clock where pix_en=1 and hcount=0 and vcount=0.
REQ-026 SHALL assume layer generators register their RGB one clock after sampling hcount/vcount.
REQ-027 SHALL delay hs/vs/de by exactly 2 clocks relative to the counter stage.
REQ-028 SHALL register the selected RGB once, so colour, sync and de change on the same edge (total latency 2 clocks from counter to pins).
REQ-029 SHALL select the menu colour when menu_layer=1 and the game colour otherwise.
REQ-030 SHALL force vga_r/g/b to 0 whenever the delayed de is 0, irrespective of layer inputs.
REQ-031 SHALL apply the pipeline every clock independent of pix_en; with PIX_DIV=2 each pixel is therefore presented for 2 clocks.
REQ-032 SHALL drive the sync output level as active = SYNC_POL and inactive = ~SYNC_POL.

Reset
REQ-033 On reset_n low, immediately: hcount=0, vcount=0, divider=0, pix_en=0 (1 if PIX_DIV=1), frame_start=0, vga_de=0, RGB=0, vga_hs/vga_vs inactive, all pipeline stages cleared.
REQ-034 Reset asserted mid-line or mid-frame SHALL abort the scan.
REQ-035 After release, the first pix_en SHALL restart scanning at (0,0) with frame_start=1.
REQ-036 Pipeline outputs SHALL stay blanked until 2 clocks after release.

Structure
REQ-037 vga_pkg SHALL hold the 640x480@60 timing constants, H_TOTAL/V_TOTAL, and the RGB332 field widths (3/3/2); vga_scan_out parameters SHALL default from it.
REQ-038 The h/v counters plus divider SHALL be one sub-module, scan_counter (outputs hcount, vcount, pix_en, frame_start); compositing and the delay line stay in vga_scan_out.

Verification
REQ-039 Reset release, PIX_DIV=1, run 2 frames -> 800 clocks per line, 420000 clocks per frame, frame_start every 420000 clocks, first pulse on the first clock after release.
REQ-040 Probe line 0 -> vga_hs low for exactly 96 clocks, falling 658 clocks after hcount=0 (656 + 2 latency); vga_vs low for exactly 2 lines (vcount 490,491, delayed 2 clocks).
REQ-041 menu_layer=1 with menu RGB 111/111/11, game RGB 001/010/01 -> output 111/111/11 in active area; menu_layer=0 -> 001/010/01; output 0 during blanking, e.g. hcount=700.
REQ-042 Counter at (799,524) -> next pix_en gives (0,0) with frame_start=1; vga_de rises 2 clocks later.
REQ-043 Assert reset_n at (300,200) for 3 clocks -> all outputs at reset values within the same clock; after release, scan restarts from (0,0).
REQ-044 PIX_DIV=2 -> pix_en every 2nd clock, 1600 clocks per line, each RGB value held 2 clocks, hs low for 192 clocks.
